// File: rtl/rs_port_arbiter_pkg.sv
// Shared encodings for the operand read-port arbiter: select codes, requester count, FSM states.
// The hold-timer constants are only referenced when RS_ARB_TIMEOUT_EN is defined.
package rs_port_arbiter_pkg;

  localparam logic [1:0] ADD    = 2'b00;
  localparam logic [1:0] MULT   = 2'b01;
  localparam logic [1:0] MULADD = 2'b10;

  localparam int NUM_REQ   = 3;
  localparam int MAX_HOLD  = 16;
  localparam int CNT_WIDTH = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  function automatic logic [1:0] onehot_to_code(input logic [NUM_REQ-1:0] oh);
    logic [1:0] code;
    case (oh)
      3'b010:  code = MULT;
      3'b100:  code = MULADD;
      default: code = ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/rs_port_arbiter_rr_pick.sv
// Combinational round-robin pick: first set req bit searching circularly from last_owner+1.
// Returns a one-hot winner and a valid flag when any request is present.
module rs_port_arbiter_rr_pick
  import rs_port_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last_owner,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  logic [2:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = {1'b0, last_owner} + 3'(i);
      if (idx >= 3'd3) idx = idx - 3'd3;
      if (!valid && req[idx[1:0]]) begin
        winner[idx[1:0]] = 1'b1;
        valid            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_port_arbiter.sv
// Round-robin owner of the register-file operand read port for ADD/MULT/MULADD.
// Optional forced preemption after MAX_HOLD grant cycles is enabled by RS_ARB_TIMEOUT_EN.
module rs_port_arbiter
  import rs_port_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [1:0]         rs_sel,
  output logic               busy,
  output logic               preempt
);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [1:0]         rs_sel_q, rs_sel_d;
  logic [1:0]         last_owner_q, last_owner_d;
  logic               busy_q;
  logic [NUM_REQ-1:0] pick_winner;
  logic               pick_valid;
  logic               owner_req;

  rs_port_arbiter_rr_pick u_rr_pick (
    .req        (req),
    .last_owner (last_owner_q),
    .winner     (pick_winner),
    .valid      (pick_valid)
  );

  assign owner_req = |(req & grant_q);

`ifdef RS_ARB_TIMEOUT_EN
  logic [CNT_WIDTH-1:0] hold_q, hold_d;
  logic                 preempt_q, preempt_d;
  logic                 contender;

  assign contender = |(req & ~grant_q);
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rs_sel_d     = rs_sel_q;
    last_owner_d = last_owner_q;
`ifdef RS_ARB_TIMEOUT_EN
    hold_d       = hold_q;
    preempt_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d      = ST_GRANT;
          grant_d      = pick_winner;
          rs_sel_d     = onehot_to_code(pick_winner);
          last_owner_d = onehot_to_code(pick_winner);
`ifdef RS_ARB_TIMEOUT_EN
          hold_d       = '0;
`endif
        end
      end
      ST_GRANT: begin
        // rs_sel is left alone on release so the mux select only moves while grant is 000
        if (!owner_req) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
`ifdef RS_ARB_TIMEOUT_EN
        else if (hold_q == CNT_WIDTH'(MAX_HOLD - 1) && contender) begin
          state_d   = ST_IDLE;
          grant_d   = '0;
          preempt_d = 1'b1;
        end else if (hold_q != '1) begin
          hold_d = hold_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      rs_sel_q     <= ADD;
      last_owner_q <= MULADD;
      busy_q       <= 1'b0;
`ifdef RS_ARB_TIMEOUT_EN
      hold_q       <= '0;
      preempt_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rs_sel_q     <= rs_sel_d;
      last_owner_q <= last_owner_d;
      busy_q       <= |grant_d;
`ifdef RS_ARB_TIMEOUT_EN
      hold_q       <= hold_d;
      preempt_q    <= preempt_d;
`endif
    end
  end

  assign grant  = grant_q;
  assign rs_sel = rs_sel_q;
  assign busy   = busy_q;
`ifdef RS_ARB_TIMEOUT_EN
  assign preempt = preempt_q;
`else
  assign preempt = 1'b0;
`endif

endmodule

// File: tb/tb_rs_port_arbiter.sv
// Scoreboard bench for rs_port_arbiter (default build, timeout feature off): driver queues
// hand-computed post-edge outputs, monitor pops and compares after every rising edge.
module tb_rs_port_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] req = 3'b000;
  logic [2:0] grant;
  logic [1:0] rs_sel;
  logic       busy;
  logic       preempt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] g;
    logic [1:0] s;
    logic       b;
    logic       p;
    string      nm;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  rs_port_arbiter dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .grant   (grant),
    .rs_sel  (rs_sel),
    .busy    (busy),
    .preempt (preempt)
  );

  function automatic void chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endfunction

  // apply inputs for one cycle and queue the outputs expected after the next rising edge
  task automatic cyc(input logic r, input logic [2:0] q, input logic [2:0] g,
                     input logic [1:0] s, input string nm);
    exp_t e;
    @(negedge clk);
    reset = r;
    req   = q;
    e.g  = g;
    e.s  = s;
    e.b  = (g != 3'b000);
    e.p  = 1'b0;
    e.nm = nm;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.nm, ".grant"},   int'(grant),   int'(e.g));
        chk({e.nm, ".rs_sel"},  int'(rs_sel),  int'(e.s));
        chk({e.nm, ".busy"},    int'(busy),    int'(e.b));
        chk({e.nm, ".preempt"}, int'(preempt), int'(e.p));
      end
    end
  end

  initial begin : driver
    // reset held with all requests up, then ADD wins first
    cyc(1, 3'b111, 3'b000, 2'b00, "rst0");
    cyc(1, 3'b111, 3'b000, 2'b00, "rst1");
    cyc(0, 3'b111, 3'b001, 2'b00, "first_grant");
    cyc(0, 3'b000, 3'b000, 2'b00, "first_release");
    cyc(0, 3'b000, 3'b000, 2'b00, "idle");

    // single ADD transaction
    for (int i = 0; i < 4; i++) cyc(0, 3'b001, 3'b001, 2'b00, "add_hold");
    cyc(0, 3'b000, 3'b000, 2'b00, "add_release");

    // round-robin rotation with all requesting, pointer back to ADD-first
    cyc(1, 3'b000, 3'b000, 2'b00, "rr_reset");
    for (int i = 0; i < 3; i++) cyc(0, 3'b111, 3'b001, 2'b00, "rr_add");
    cyc(0, 3'b110, 3'b000, 2'b00, "rr_bubble0");
    for (int i = 0; i < 3; i++) cyc(0, 3'b111, 3'b010, 2'b01, "rr_mult");
    cyc(0, 3'b101, 3'b000, 2'b01, "rr_bubble1");
    for (int i = 0; i < 3; i++) cyc(0, 3'b111, 3'b100, 2'b10, "rr_muladd");
    cyc(0, 3'b011, 3'b000, 2'b10, "rr_bubble2");
    cyc(0, 3'b111, 3'b001, 2'b00, "rr_wrap_add");
    cyc(0, 3'b000, 3'b000, 2'b00, "rr_release");

    // MULT owns while ADD keeps requesting: no preemption in this build
    for (int i = 0; i < 100; i++) cyc(0, 3'b011, 3'b010, 2'b01, "mult_hold");
    cyc(0, 3'b000, 3'b000, 2'b01, "mult_release");

    // reset in the middle of a MULADD grant
    for (int i = 0; i < 3; i++) cyc(0, 3'b100, 3'b100, 2'b10, "muladd_hold");
    cyc(1, 3'b100, 3'b000, 2'b00, "midgrant_reset");
    cyc(0, 3'b110, 3'b010, 2'b01, "post_reset_mult");
    cyc(0, 3'b000, 3'b000, 2'b01, "post_reset_release");

    // owner drops while another raises in the same cycle
    cyc(0, 3'b001, 3'b001, 2'b00, "handover_add");
    cyc(0, 3'b001, 3'b001, 2'b00, "handover_add_hold");
    cyc(0, 3'b100, 3'b000, 2'b00, "handover_bubble");
    cyc(0, 3'b100, 3'b100, 2'b10, "handover_muladd");
    cyc(0, 3'b000, 3'b000, 2'b10, "handover_release");
    cyc(0, 3'b000, 3'b000, 2'b10, "final_idle");

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
